// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - press/release event classifier with repeat filter feeding a FWFT event FIFO
module key_event_fifo #(
    parameter int DEPTH         = 8,
    parameter int ADDR_W        = 3,
    parameter bit REPEAT_FILTER = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic [8:0]        key_code,
    input  logic [511:0]      key_down,
    input  logic              ev_rd,
    input  logic              ovf_clr,
    output logic              ev_valid,
    output logic [8:0]        ev_code,
    output logic              ev_press,
    output logic [ADDR_W:0]   ev_count,
    output logic              full,
    output logic              overflow
);

    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    // Entry layout: bit 9 = press, bits 8:0 = key code
    logic [9:0]        mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count;
    logic [511:0]      held;

    logic press;
    logic is_repeat;
    logic candidate;
    logic pop;
    logic push;
    logic drop;

    // Classify the incoming event and resolve push/pop/drop for this cycle
    always_comb begin
        press     = key_down[key_code];
        is_repeat = REPEAT_FILTER && press && held[key_code];
        candidate = key_valid && !is_repeat;
        pop       = ev_rd && ev_valid;
        // A pop frees the head slot in the same cycle, so a full FIFO still accepts
        push      = candidate && (!full || pop);
        drop      = candidate && full && !pop;
    end

    // Track which keys are currently held; updated on every event, even dropped ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held <= '0;
        end else if (key_valid) begin
            held[key_code] <= press;
        end
    end

    // Entry storage; cleared on reset so the head outputs read as zero while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            // When full with a pop, wr_ptr equals rd_ptr: the old head is overwritten as it leaves
            mem[wr_ptr] <= {press, key_code};
        end
    end

    // Write pointer advances on each accepted push, wrapping modulo DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    // Read pointer advances on each pop, wrapping modulo DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Occupancy count: simultaneous push and pop leave it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + COUNT_ONE;
        end else if (pop && !push) begin
            count <= count - COUNT_ONE;
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // First-word-fall-through head presentation and status flags
    always_comb begin
        ev_valid = (count != '0);
        full     = (count == COUNT_FULL);
        ev_count = count;
        ev_code  = mem[rd_ptr][8:0];
        ev_press = mem[rd_ptr][9];
    end

endmodule

// File: doc/key_event_fifo.md
Name: key_event_fifo

Overview:
- Sits directly downstream of the PS/2 keyboard decoder. Consumes its per-event strobe, 9-bit key code and 512-bit key-state vector.
- Turns these into discrete press/release events, drops typematic auto-repeat presses, and buffers the events in a small first-word-fall-through FIFO.
- Game control logic pops events at its own pace, so no keystroke is lost while the game FSM is busy.

Parameters:
- DEPTH, 8, number of event entries; must be a power of 2, minimum 2.
- ADDR_W, 3, log2(DEPTH).
- REPEAT_FILTER, 1, 1 = drop press events for keys already held; 0 = enqueue every press.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_valid  input  1  one-cycle strobe from the decoder; the event code is on key_code.
- key_code  input  9  {extend, scan[7:0]} of the event; sampled only when key_valid=1.
- key_down  input  512  decoder key-state vector. Already updated in the cycle key_valid=1.
- ev_rd  input  1  consumer pop request; acts only when ev_valid=1.
- ovf_clr  input  1  clears the sticky overflow flag.
- ev_valid  output  1  FIFO non-empty; head entry is presented.
- ev_code  output  9  key code of the head entry.
- ev_press  output  1  1 = make (press), 0 = break (release), for the head entry.
- ev_count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
- full  output  1  ev_count==DEPTH.
- overflow  output  1  sticky; set when an event is dropped because the FIFO is full.

Behaviour:
- Reset (rst_n=0, async): rd_ptr=wr_ptr=0, ev_count=0, ev_valid=0, full=0, overflow=0, held[511:0]=0. ev_code/ev_press are don't-care while empty but must reset to 0. Reset mid-operation discards all entries and held state.
- Event classification, in a cycle with key_valid=1:
  - press = key_down[key_code]. No other decode is permitted; there is no separate break input.
  - held[key_code] <= press on every key_valid, whether or not the event is enqueued.
  - Candidate push = key_valid AND NOT (REPEAT_FILTER AND press AND held[key_code]).
  - A release is always a candidate, even if held[key_code]=0 (e.g. key held across reset).
- FIFO storage:
  - Entry = {press, code[8:0]}, 10 bits.
  - Storage array is DEPTH x 10; pointers are ADDR_W bits and wrap modulo DEPTH.
  - A count register (ADDR_W+1 bits) distinguishes full from empty.
- Push and pop rules:
  - pop = ev_rd AND ev_valid. ev_rd while empty is ignored with no side effects.
  - push_ok = candidate AND (NOT full OR pop). A simultaneous push and pop while full is accepted; count stays DEPTH.
  - If candidate AND full AND NOT pop: the event is dropped and overflow <= 1. held is still updated.
  - Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
  - Simultaneous push and pop at count 1: the head advances to the new entry; ev_valid stays 1.
- Latency:
  - A pushed event is visible at ev_valid/ev_code/ev_press on the cycle after key_valid.
  - Outputs are first-word-fall-through, combinational from storage[rd_ptr].
  - After a pop, the next entry is presented on the following cycle.
- Overflow:
  - overflow stays set until ovf_clr=1. ovf_clr clears it on the next edge.
  - If a drop and ovf_clr occur in the same cycle, the set wins (overflow=1).
- Invariant: key_valid is at most one cycle wide and never back-to-back from the decoder. The block must still accept key_valid on consecutive cycles correctly.

Test Plan:
- Reset, then key_valid with key_code=0x01C, key_down[0x01C]=1 -> next cycle ev_valid=1, ev_code=0x01C, ev_press=1, ev_count=1.
- Three presses of 0x01C without a release (typematic), REPEAT_FILTER=1 -> exactly 1 entry. With REPEAT_FILTER=0 -> 3 entries.
- Press 0x11D, then release 0x11D (key_down[0x11D]=0), pop twice with ev_rd -> {1,0x11D} then {0,0x11D}, then ev_valid=0 and ev_count=0.
- Fill with 8 distinct presses -> full=1. A 9th press without ev_rd -> dropped, overflow=1, count=8. Pulse ovf_clr -> overflow=0.
- With full=1, a press and ev_rd in the same cycle -> count stays 8, the new entry is last, the oldest is removed. Wrap-around is checked by pushing and popping 20 events with ordering preserved.
- Assert rst_n=0 asynchronously mid-clock with 5 entries -> ev_valid=0, ev_count=0 immediately. After release, a release event for a previously held key is still enqueued with ev_press=0.
